// File: rtl/forth_pkg.sv
// Shared Forth front-end constants: delimiters, ASCII digits/sign,
// tokenizer state encoding and key shape defaults.
package forth_pkg;

  localparam int KEY_WIDTH_DEF   = 8;
  localparam int KEY_LENGTH_DEF  = 8;
  localparam int VALUE_WIDTH_DEF = 32;

  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_NUL = 8'h00;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;

  typedef enum logic [1:0] {
    ST_SKIP  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } tok_state_e;

endpackage

// File: rtl/tok_dec_accum.sv
// Signed decimal literal recogniser for one word, fed a char per strobe.
// o_acc already carries the sign; o_is_num is 1 only for [-]digit+.
module tok_dec_accum
  import forth_pkg::*;
#(
  parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_strobe,
  input  logic [KEY_WIDTH-1:0]   i_char,
  output logic [VALUE_WIDTH-1:0] o_acc,
  output logic                   o_is_num
);

  logic [VALUE_WIDTH-1:0] r_acc;
  logic                   r_neg;
  logic                   r_seen;
  logic                   r_bad;

  logic                   w_is_digit;
  logic                   w_minus;
  logic [VALUE_WIDTH-1:0] w_digit;
  logic [VALUE_WIDTH-1:0] w_next;

  assign w_is_digit = (i_char >= KEY_WIDTH'(CH_0)) &&
                      (i_char <= KEY_WIDTH'(CH_9));
  assign w_minus    = (i_char == KEY_WIDTH'(CH_MINUS));
  assign w_digit    = VALUE_WIDTH'(i_char[3:0]);
  // acc*10 + d, wrapping modulo 2^VALUE_WIDTH
  assign w_next     = (r_acc << 3) + (r_acc << 1) + w_digit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_neg  <= 1'b0;
      r_seen <= 1'b0;
      r_bad  <= 1'b0;
    end else if (i_strobe) begin
      if (i_clear) begin
        r_neg  <= w_minus;
        r_seen <= w_is_digit;
        r_bad  <= !w_minus && !w_is_digit;
        r_acc  <= w_is_digit ? w_digit : '0;
      end else if (w_is_digit) begin
        r_acc  <= w_next;
        r_seen <= 1'b1;
      end else begin
        r_bad  <= 1'b1;
      end
    end
  end

  assign o_acc    = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign o_is_num = r_seen && !r_bad;

endmodule

// File: rtl/word_tokenizer.sv
// Whitespace word splitter producing zero-padded fixed-length keys.
// Define TOKENIZER_NUMBER_EN to add the signed decimal literal parse.
module word_tokenizer
  import forth_pkg::*;
#(
  parameter int KEY_WIDTH   = KEY_WIDTH_DEF,
  parameter int KEY_LENGTH  = KEY_LENGTH_DEF
`ifdef TOKENIZER_NUMBER_EN
  ,
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic [KEY_WIDTH-1:0]   i_char,
  output logic                   o_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [KEY_WIDTH-1:0]   o_key [KEY_LENGTH-1:0],
  output logic [$clog2(KEY_LENGTH+1)-1:0] o_len,
  output logic                   o_trunc
`ifdef TOKENIZER_NUMBER_EN
  ,
  output logic                   o_is_num,
  output logic [VALUE_WIDTH-1:0] o_num
`endif
);

  localparam int LW = $clog2(KEY_LENGTH+1);

  tok_state_e           r_state;
  logic [KEY_WIDTH-1:0] r_key [KEY_LENGTH-1:0];
  logic [LW-1:0]        r_len;
  logic                 r_trunc;
  logic                 r_valid;

  logic w_delim;
  logic w_take;

  assign w_delim = (i_char == KEY_WIDTH'(CH_SP))  ||
                   (i_char == KEY_WIDTH'(CH_TAB)) ||
                   (i_char == KEY_WIDTH'(CH_LF))  ||
                   (i_char == KEY_WIDTH'(CH_CR))  ||
                   (i_char == KEY_WIDTH'(CH_NUL));

  assign o_ready = (r_state != ST_EMIT) && !i_rst;
  assign w_take  = i_valid && o_ready;

`ifdef TOKENIZER_NUMBER_EN
  logic [VALUE_WIDTH-1:0] w_acc;
  logic                   w_is_num;
  logic                   r_is_num;
  logic [VALUE_WIDTH-1:0] r_num;

  tok_dec_accum #(
    .KEY_WIDTH   (KEY_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) u_dec (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (r_state == ST_SKIP),
    .i_strobe (w_take && !w_delim),
    .i_char   (i_char),
    .o_acc    (w_acc),
    .o_is_num (w_is_num)
  );

  // Latch the parse as the word closes so it stays stable through EMIT
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_is_num <= 1'b0;
      r_num    <= '0;
    end else if (r_state == ST_ACCUM && w_take && w_delim) begin
      r_is_num <= w_is_num;
      r_num    <= w_is_num ? w_acc : '0;
    end
  end

  assign o_is_num = r_is_num;
  assign o_num    = r_num;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_SKIP;
      r_len   <= '0;
      r_trunc <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i < KEY_LENGTH; i++)
        r_key[i] <= '0;
    end else begin
      unique case (r_state)
        ST_SKIP: begin
          if (w_take && !w_delim) begin
            for (int i = 0; i < KEY_LENGTH; i++)
              r_key[i] <= '0;
            r_key[0] <= i_char;
            r_len    <= LW'(1);
            r_trunc  <= 1'b0;
            r_state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_take) begin
            if (w_delim) begin
              r_valid <= 1'b1;
              r_state <= ST_EMIT;
            end else if (r_len < LW'(KEY_LENGTH)) begin
              for (int i = 0; i < KEY_LENGTH; i++)
                if (r_len == LW'(i))
                  r_key[i] <= i_char;
              r_len <= r_len + LW'(1);
            end else begin
              r_trunc <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_SKIP;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_SKIP;
        end
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_key   = r_key;
  assign o_len   = r_len;
  assign o_trunc = r_trunc;

endmodule

// File: tb/tb_word_tokenizer.sv
// Scoreboard bench for word_tokenizer: word-level reference model,
// directed streams plus randomized words with random consumer stalls.
module tb_word_tokenizer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_char = 8'h00;
  logic       i_ready = 1'b1;
  logic       o_ready;
  logic       o_valid;
  logic [7:0] o_key [7:0];
  logic [3:0] o_len;
  logic       o_trunc;
`ifdef TOKENIZER_NUMBER_EN
  logic        o_is_num;
  logic [31:0] o_num;
`endif

  word_tokenizer dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_char  (i_char),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_key   (o_key),
    .o_len   (o_len),
    .o_trunc (o_trunc)
`ifdef TOKENIZER_NUMBER_EN
    ,
    .o_is_num (o_is_num),
    .o_num    (o_num)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] key;
    int          len;
    bit          trunc;
    bit          isnum;
    logic [31:0] num;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] cur[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_due = -1;
  int rdy_mode = 0;

  logic [63:0] m_key;
  logic [63:0] h_key;
  logic [3:0]  h_len;
  bit          held = 0;
  exp_t        m_e;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit is_delim(input logic [7:0] b);
    return b == 8'h20 || b == 8'h09 || b == 8'h0A ||
           b == 8'h0D || b == 8'h00;
  endfunction

  // Reference: the word text as a whole, keyed, truncated and parsed
  function automatic exp_t make_word();
    exp_t e;
    int n;
    int st;
    logic [31:0] acc;
    n = cur.size();
    e.key = '0;
    for (int i = 0; i < n && i < 8; i++)
      e.key[8*i +: 8] = cur[i];
    e.len   = (n > 8) ? 8 : n;
    e.trunc = (n > 8);
    st  = (cur[0] == 8'h2D) ? 1 : 0;
    e.isnum = (n > st);
    acc = 0;
    for (int i = st; i < n; i++) begin
      if (cur[i] >= 8'h30 && cur[i] <= 8'h39)
        acc = acc * 10 + 32'(cur[i] - 8'h30);
      else
        e.isnum = 0;
    end
    if (st == 1) acc = -acc;
    e.num = e.isnum ? acc : 32'h0;
    return e;
  endfunction

  task automatic model_accept(input logic [7:0] b);
    if (is_delim(b)) begin
      if (cur.size() > 0) begin
        sbq.push_back(make_word());
        rise_due = cyc + 1;
        cur.delete();
      end
    end else begin
      cur.push_back(b);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_char  = b;
      if (o_ready) begin
        model_accept(b);
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stuck required=accept char=%h", b);
    end
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_char  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if ($urandom_range(0, 4) == 0) idle();
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sbq.size() > 0; t++)
      @(negedge i_clk);
    checks++;
    if (sbq.size() > 0) begin
      failures++;
      $display("FAIL drain actual=%0d_pending required=0", sbq.size());
    end
  endtask

  function automatic logic [63:0] key_flat();
    logic [63:0] k;
    for (int i = 0; i < 8; i++)
      k[8*i +: 8] = o_key[i];
    return k;
  endfunction

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
  end

  // Monitor: checks latency, hold stability and pops on each transfer
  always @(negedge i_clk) begin
    if (i_rst) begin
      held = 0;
    end else begin
      m_key = key_flat();
      if (cyc == rise_due)
        chk("valid_latency", 64'(o_valid), 64'd1);
      if (o_valid)
        chk("ready_in_emit", 64'(o_ready), 64'd0);
      if (held) begin
        chk("hold_valid", 64'(o_valid), 64'd1);
        chk("hold_key", m_key, h_key);
        chk("hold_len", 64'(o_len), 64'(h_len));
      end
      held  = o_valid && !i_ready;
      h_key = m_key;
      h_len = o_len;
      if (o_valid && i_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_word actual=%h required=none", m_key);
        end else begin
          m_e = sbq.pop_front();
          chk("key", m_key, m_e.key);
          chk("len", 64'(o_len), 64'(m_e.len));
          chk("trunc", 64'(o_trunc), 64'(m_e.trunc));
`ifdef TOKENIZER_NUMBER_EN
          chk("is_num", 64'(o_is_num), 64'(m_e.isnum));
          chk("num", 64'(o_num), 64'(m_e.num));
`endif
        end
      end
    end
  end

  initial begin
    int wl;
    int r;
    logic [7:0] c;
    bit seen;

    #12;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd0);
    chk("rst_len", 64'(o_len), 64'd0);
    chk("rst_trunc", 64'(o_trunc), 64'd0);
    chk("rst_key", key_flat(), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 chk("ready_after_rst", 64'(o_ready), 64'd1);

    rdy_mode = 0;
    send_str("  DUP\n");
    idle();
    drain();

    send_str("ABCDEFGHIJ ");
    idle();
    drain();

    send_str("\t\t \r\n");
    idle();
    repeat (6) @(negedge i_clk);

    rdy_mode = 2;
    fork
      begin
        send_str("A B");
        send_byte(8'h00);
        idle();
      end
      begin
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge i_clk);
          seen = o_valid;
        end
        checks++;
        if (!seen) begin
          failures++;
          $display("FAIL stall_wait actual=0 required=1");
        end
        repeat (5) @(posedge i_clk);
        rdy_mode = 0;
      end
    join
    drain();

    send_str("SW");
    idle();
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    cur.delete();
    #1;
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_len", 64'(o_len), 64'd0);
    chk("mid_rst_ready", 64'(o_ready), 64'd0);
    chk("mid_rst_key", key_flat(), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    send_str("OK ");
    idle();
    drain();

    send_str("-42 4x2 - 123456789012 0 --5 -007\r");
    idle();
    drain();

    rdy_mode = 1;
    for (int w = 0; w < 40; w++) begin
      wl = $urandom_range(1, 12);
      for (int i = 0; i < wl; i++) begin
        r = $urandom_range(0, 9);
        if (r < 4)       c = 8'($urandom_range(8'h30, 8'h39));
        else if (r == 4) c = 8'h2D;
        else if (r < 8)  c = 8'($urandom_range(8'h41, 8'h5A));
        else             c = 8'($urandom_range(8'h21, 8'hFF));
        send_byte(c);
        if ($urandom_range(0, 5) == 0) idle();
      end
      r = $urandom_range(1, 3);
      for (int i = 0; i < r; i++) begin
        case ($urandom_range(0, 4))
          0:       send_byte(8'h20);
          1:       send_byte(8'h09);
          2:       send_byte(8'h0A);
          3:       send_byte(8'h0D);
          default: send_byte(8'h00);
        endcase
      end
    end
    idle();
    drain();
    rdy_mode = 0;
    repeat (4) @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
